// File: rtl/sfp_pkg.sv
// sfp_pkg: shared constants and state encodings for the SFP RX word aligner.
package sfp_pkg;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam int LANE_W = 2;
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } align_state_e;
endpackage

// File: rtl/sfp_comma_detect.sv
// sfp_comma_detect: flags a word carrying exactly one K byte equal to COMMA_BYTE and reports its lane.
//   in  rx_data[31:0], rx_charisk[3:0]
//   out comma_vld, comma_lane[1:0]
module sfp_comma_detect
  import sfp_pkg::*;
#(
  parameter logic [7:0] COMMA_BYTE = K28_5
) (
  input  logic [31:0]       rx_data,
  input  logic [3:0]        rx_charisk,
  output logic              comma_vld,
  output logic [LANE_W-1:0] comma_lane
);
  always_comb begin
    comma_vld  = 1'b0;
    comma_lane = '0;
    for (int i = 0; i < 4; i++)
      if (rx_charisk == 4'(1 << i) && rx_data[8*i +: 8] == COMMA_BYTE) begin
        comma_vld  = 1'b1;
        comma_lane = LANE_W'(i);
      end
  end
endmodule

// File: rtl/sfp_rx_word_align.sv
// sfp_rx_word_align: finds the comma lane, qualifies lock and rotates RX words so commas exit on byte 0.
//   in  rx_clk, rx_rst_n (async, active low), rx_data[31:0], rx_charisk[3:0], rx_code_err[3:0]
//   out rx_data_align[31:0], rx_charisk_align[3:0], align_locked, align_offset[1:0],
//       realign_cnt[15:0], code_err_cnt[15:0]
//   SFP_ALIGN_STAT_EN: defined enables the saturating statistics counters, otherwise they read 0.
module sfp_rx_word_align
  import sfp_pkg::*;
#(
  parameter logic [7:0] COMMA_BYTE = K28_5,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 4
) (
  input  logic        rx_clk,
  input  logic        rx_rst_n,
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_charisk,
  input  logic [3:0]  rx_code_err,
  output logic [31:0] rx_data_align,
  output logic [3:0]  rx_charisk_align,
  output logic        align_locked,
  output logic [1:0]  align_offset,
  output logic [15:0] realign_cnt,
  output logic [15:0] code_err_cnt
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic              comma_vld;
  logic [LANE_W-1:0] comma_lane;
  logic              err;
  align_state_e      state_q, state_d;
  logic [LANE_W-1:0] cand_q, cand_d, off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, bad_q, bad_d;
  logic [31:0]       prev_data_q, data_q, data_d, rot_data;
  logic [3:0]        prev_k_q, k_q, k_d, rot_k;
  logic              locked_q, locked_d;

  sfp_comma_detect #(.COMMA_BYTE(COMMA_BYTE)) u_det (
    .rx_data    (rx_data),
    .rx_charisk (rx_charisk),
    .comma_vld  (comma_vld),
    .comma_lane (comma_lane)
  );

  assign err = |rx_code_err;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    off_d   = off_q;
    case (state_q)
      SEARCH: if (comma_vld) begin
        cand_d  = comma_lane;
        cnt_d   = ONE;
        state_d = (LOCK_CNT == 1) ? LOCKED : CHECK;
        off_d   = (LOCK_CNT == 1) ? comma_lane : off_q;
      end
      CHECK: if (err) begin
        state_d = SEARCH;
        cnt_d   = '0;
      end else if (comma_vld && comma_lane == cand_q) begin
        cnt_d   = cnt_q + ONE;
        state_d = (cnt_q + ONE == CNT_W'(LOCK_CNT)) ? LOCKED : CHECK;
        off_d   = (cnt_q + ONE == CNT_W'(LOCK_CNT)) ? cand_q : off_q;
      end else if (comma_vld) begin
        cand_d = comma_lane;
        cnt_d  = ONE;
      end
      LOCKED: if (err || (comma_vld && comma_lane != off_q)) begin
        // A wrong-lane comma and a code error in the same word are one bad event.
        state_d = (bad_q + ONE == CNT_W'(UNLOCK_CNT)) ? SEARCH : LOCKED;
        bad_d   = (bad_q + ONE == CNT_W'(UNLOCK_CNT)) ? '0 : bad_q + ONE;
      end else if (comma_vld) begin
        bad_d = '0;
      end
      default: state_d = SEARCH;
    endcase
  end

  // Window {rx_data, prev} shifted down by k bytes; top byte of rx_data never reaches the output.
  always_comb begin
    rot_data = off_q == 2'd0 ? prev_data_q :
               off_q == 2'd1 ? {rx_data[7:0],  prev_data_q[31:8]}  :
               off_q == 2'd2 ? {rx_data[15:0], prev_data_q[31:16]} :
                               {rx_data[23:0], prev_data_q[31:24]};
    rot_k    = off_q == 2'd0 ? prev_k_q :
               off_q == 2'd1 ? {rx_charisk[0],   prev_k_q[3:1]} :
               off_q == 2'd2 ? {rx_charisk[1:0], prev_k_q[3:2]} :
                               {rx_charisk[2:0], prev_k_q[3]};
    locked_d = state_q == LOCKED;
    data_d   = locked_d ? rot_data : '0;
    k_d      = locked_d ? rot_k : '0;
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n)
    if (!rx_rst_n) begin
      state_q     <= SEARCH;
      cand_q      <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      bad_q       <= '0;
      prev_data_q <= '0;
      prev_k_q    <= '0;
      data_q      <= '0;
      k_q         <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      bad_q       <= bad_d;
      prev_data_q <= rx_data;
      prev_k_q    <= rx_charisk;
      data_q      <= data_d;
      k_q         <= k_d;
      locked_q    <= locked_d;
    end

  assign rx_data_align    = data_q;
  assign rx_charisk_align = k_q;
  assign align_locked     = locked_q;
  assign align_offset     = off_q;

`ifdef SFP_ALIGN_STAT_EN
  logic [15:0] realign_q, realign_d, code_err_q, code_err_d;
  always_comb begin
    realign_d  = (state_q == LOCKED && state_d == SEARCH && realign_q != 16'hFFFF) ?
                 realign_q + 16'd1 : realign_q;
    code_err_d = (err && code_err_q != 16'hFFFF) ? code_err_q + 16'd1 : code_err_q;
  end
  always_ff @(posedge rx_clk or negedge rx_rst_n)
    if (!rx_rst_n) begin
      realign_q  <= '0;
      code_err_q <= '0;
    end else begin
      realign_q  <= realign_d;
      code_err_q <= code_err_d;
    end
  assign realign_cnt  = realign_q;
  assign code_err_cnt = code_err_q;
`else
  assign realign_cnt  = '0;
  assign code_err_cnt = '0;
`endif
endmodule
